// File: rtl/udp_tx_sched.sv
// Two-channel round-robin scheduler in front of the UDP transmit core.
// Handles grant, start pulse, byte steering, inter-packet gap and done watchdog.
module udp_tx_sched #(
  parameter logic [15:0] MAX_BYTES      = 16'd1472,
  parameter int          IFG_CYCLES     = 16,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic        ch0_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [7:0]  ch0_data,
  output logic        ch0_gnt,
  output logic        ch0_rd_en,
  output logic        ch0_done,
  output logic        ch0_reject,
  input  logic        ch1_req,
  input  logic [15:0] ch1_byte_num,
  input  logic [7:0]  ch1_data,
  output logic        ch1_gnt,
  output logic        ch1_rd_en,
  output logic        ch1_done,
  output logic        ch1_reject,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  input  logic        tx_req,
  input  logic        udp_tx_done,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  localparam logic [15:0] IFG_LOAD = 16'(IFG_CYCLES);
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state;
  logic        rr;
  logic [16:0] beat_cnt;
  logic [31:0] wd_cnt;
  logic [15:0] gap_cnt;

  logic        cand;
  logic        cand_valid;
  logic [15:0] cand_len;
  logic        cand_ok;

  always_comb begin
    cand_valid = ch0_req | ch1_req;
    cand       = (ch0_req & ch1_req) ? rr : ch1_req;
    cand_len   = cand ? ch1_byte_num : ch0_byte_num;
    cand_ok    = (cand_len != 16'd0) && (cand_len <= MAX_BYTES);
  end

  assign ch0_rd_en = (state == WAIT_DONE) & tx_req & ch0_gnt;
  assign ch1_rd_en = (state == WAIT_DONE) & tx_req & ch1_gnt;
  assign tx_data   = ch0_gnt ? ch0_data : (ch1_gnt ? ch1_data : 8'd0);
  assign busy      = (state != IDLE);

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= 1'b0;
      beat_cnt    <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      ch0_gnt     <= 1'b0;
      ch1_gnt     <= 1'b0;
      ch0_done    <= 1'b0;
      ch1_done    <= 1'b0;
      ch0_reject  <= 1'b0;
      ch1_reject  <= 1'b0;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      tx_start_en <= 1'b0;
      ch0_done    <= 1'b0;
      ch1_done    <= 1'b0;
      ch0_reject  <= 1'b0;
      ch1_reject  <= 1'b0;
      case (state)
        IDLE: begin
          // A request that was just refused is not looked at again until its reject pulse ends
          if (cand_valid && !ch0_reject && !ch1_reject) begin
            rr <= ~cand;
            if (cand_ok) begin
              tx_byte_num <= cand_len;
              ch0_gnt     <= ~cand;
              ch1_gnt     <= cand;
              tx_start_en <= 1'b1;
              state       <= START;
            end else begin
              ch0_reject <= ~cand;
              ch1_reject <= cand;
            end
          end
        end
        START: begin
          beat_cnt <= '0;
          wd_cnt   <= 32'd1;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_req) begin
            beat_cnt <= beat_cnt + 17'd1;
            if ((beat_cnt + 17'd1) > {1'b0, tx_byte_num}) overrun_err <= 1'b1;
          end
          // Watchdog counts cycles since the start pulse; a real done always wins
          if (udp_tx_done || (wd_cnt + 32'd1 >= TO_LIMIT)) begin
            if (!udp_tx_done) timeout_err <= 1'b1;
            ch0_done <= ch0_gnt;
            ch1_done <= ch1_gnt;
            ch0_gnt  <= 1'b0;
            ch1_gnt  <= 1'b0;
            gap_cnt  <= IFG_LOAD;
            if (IFG_CYCLES == 0) state <= IDLE;
            else                 state <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        GAP: begin
          if (gap_cnt <= 16'd1) state <= IDLE;
          else                  gap_cnt <= gap_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
